// File: rtl/audio_stream_mixer.sv
// audio_stream_mixer: captures level-held sample pairs, applies the volumes, mixes them and sends each result through a FIFO to both codec channels.
// Define AUDIO_MIXER_SAT_EN to clamp the mixed sum instead of letting it wrap.
module audio_stream_mixer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_bgm_data,
  input  logic        in_bgm_valid,
  input  logic [15:0] in_sfx_data,
  input  logic        in_sfx_valid,
  output logic        up_ready,
  input  logic [3:0]  bgm_vol,
  input  logic [3:0]  sfx_vol,
  output logic [15:0] out_l_data,
  output logic        out_l_valid,
  input  logic        out_l_ready,
  output logic [15:0] out_r_data,
  output logic        out_r_valid,
  input  logic        out_r_ready,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, DROP} state_t;
  state_t state_q, state_d;
  logic cap, inflight_q, acc_l_q, acc_r_q, overflow_q;
  logic [15:0] bgm_q, sfx_q, mixed;
  logic [15:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic signed [15:0] sb, ss;
  logic signed [20:0] pb, ps;
  logic signed [17:0] sum;
  logic sum_ovf, nonempty, xfer_l, xfer_r, pop;

  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = state_q == IDLE ? (cap ? DROP : IDLE)
                              : (!in_bgm_valid && !in_sfx_valid ? IDLE : DROP);

  // The sample sitting in the mix stage already owns a FIFO slot.
  always_comb begin
    up_ready = state_q == IDLE &&
               ({1'b0, count_q} + (AW+2)'(inflight_q) < (AW+2)'(DEPTH));
    cap = up_ready && in_bgm_valid && in_sfx_valid;
  end

  always_comb begin
    sb = {~bgm_q[15], bgm_q[14:0]};
    ss = {~sfx_q[15], sfx_q[14:0]};
    pb = 21'(sb) * 21'($signed({1'b0, bgm_vol}));
    ps = 21'(ss) * 21'($signed({1'b0, sfx_vol}));
    sum = 18'(pb >>> 3) + 18'(ps >>> 3);
    sum_ovf = !(&sum[17:15] || !(|sum[17:15]));
`ifdef AUDIO_MIXER_SAT_EN
    mixed = sum_ovf ? (sum[17] ? 16'h8000 : 16'h7FFF) : sum[15:0];
`else
    mixed = sum[15:0];
`endif
  end

  always_comb begin
    nonempty = count_q != '0;
    out_l_valid = nonempty && !acc_l_q;
    out_r_valid = nonempty && !acc_r_q;
    xfer_l = out_l_valid && out_l_ready;
    xfer_r = out_r_valid && out_r_ready;
    pop = nonempty && (acc_l_q || xfer_l) && (acc_r_q || xfer_r);
    out_l_data = nonempty ? mem_q[rd_q] : '0;
    out_r_data = out_l_data;
    overflow = overflow_q;
  end

  always_ff @(posedge clk)
    if (inflight_q) mem_q[wr_q] <= mixed;

  always_ff @(posedge clk) begin
    if (cap) begin
      bgm_q <= in_bgm_data;
      sfx_q <= in_sfx_data;
    end
    if (reset) begin
      inflight_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      acc_l_q <= 1'b0;
      acc_r_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      inflight_q <= cap;
      if (inflight_q) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + (AW+1)'(inflight_q) - (AW+1)'(pop);
      acc_l_q <= !pop && (acc_l_q || xfer_l);
      acc_r_q <= !pop && (acc_r_q || xfer_r);
      overflow_q <= overflow_q || (inflight_q && sum_ovf);
    end
  end
endmodule
